alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter FUNC_W, default 6, func field width; SHALL be >= 6, and only func[5:0] is decoded.
REQ-002 SHALL have parameter MD_CYCLES, default 32, multiply/divide occupancy in cycles; SHALL be >= 2.
REQ-003 SHALL have parameter ENABLE_MULDIV, default 1; when 0, mult/div funcs decode as illegal.
REQ-004 SHALL have the following ports, clock and reset first:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present on alu_op/func.
- in_ready  output  1  sequencer accepts a request this cycle.
- alu_op  input  3  operation class from the control block.
- func  input  FUNC_W  instruction function field.
- out_valid  output  1  alu_ctrl/illegal hold a valid result.
- out_ready  input  1  downstream consumes the result.
- alu_ctrl  output  4  registered ALU control code.
- illegal  output  1  registered; current result is an undefined opcode.
- md_start  output  1  one-cycle pulse starting the multi-cycle unit.
- md_busy  output  1  multi-cycle operation in progress.

Function
REQ-005 SHALL decode alu_op as: 000 add 0010; 001 sub 0110; 010 R-type (REQ-006); 011 and 0000; 100 or 0001; 101 slt 0111; 110/111 illegal.
REQ-006 SHALL decode R-type func[5:0] as: 100000 add 0010; 100010 sub 0110; 100100 and 0000; 100101 or 0001; 100111 nor 1100; 101010 slt 0111; 011000 mult 1000; 011010 div 1001; all others illegal.
REQ-007 SHALL produce alu_ctrl 1111 and illegal=1 for any illegal decode; illegal requests take the single-cycle path.
REQ-008 SHALL implement an FSM with states IDLE, BUSY and OUT.
REQ-009 IDLE: in_ready=1, out_valid=0; a transfer (in_valid and in_ready) loads alu_ctrl/illegal and goes to OUT, or to BUSY for legal mult/div.
REQ-010 Entry to BUSY: md_start=1 for exactly the first BUSY cycle, down-counter loaded with MD_CYCLES-1, md_busy=1 throughout BUSY, in_ready=0.
REQ-011 BUSY: counter decrements by 1 per cycle; on the cycle it reads 0, the FSM goes to OUT; BUSY therefore lasts exactly MD_CYCLES cycles.
REQ-012 OUT: out_valid=1; alu_ctrl and illegal SHALL stay stable while out_ready=0.
REQ-013 OUT with out_ready=1: in_ready=1; a simultaneous transfer loads the new request and applies REQ-009 next-state rules; otherwise the FSM returns to IDLE.
REQ-014 Single-cycle latency SHALL be one cycle, from transfer edge to out_valid; sustained throughput SHALL be one result per cycle while out_ready=1.
REQ-015 Mult/div latency SHALL be MD_CYCLES+1 cycles, from transfer edge to out_valid.
REQ-016 in_ready SHALL be purely a function of state and out_ready, never of in_valid.
REQ-017 Inputs SHALL be ignored whenever in_ready=0; no request may be lost or duplicated.

Reset
REQ-018 rst=1 SHALL immediately force: state IDLE, alu_ctrl 0000, illegal=0, out_valid=0, md_start=0, md_busy=0, counter 0.
REQ-019 Reset asserted during BUSY or OUT SHALL abort the operation with no result delivered; after release, the first accepted request behaves as from power-up.

Verification
REQ-020 Bench: alu_op=010, func=100010, out_ready=1 -> next cycle out_valid=1, alu_ctrl=0110, illegal=0.
REQ-021 Bench: back-to-back add, or, slt requests with out_ready=1 -> results 0010, 0001, 0111 on consecutive cycles; in_ready stays 1.
REQ-022 Bench: MD_CYCLES=4, func=011010 -> md_start pulses one cycle, md_busy=1 for 4 cycles, in_ready=0 during BUSY, out_valid=1 with alu_ctrl=1001 at cycle 5.
REQ-023 Bench: alu_op=010, func=000001, and separately alu_op=111 -> alu_ctrl=1111, illegal=1; with ENABLE_MULDIV=0, func=011000 -> illegal=1.
REQ-024 Bench: out_ready=0 for 3 cycles in OUT -> alu_ctrl held, in_ready=0, then a single transfer on out_ready=1.
REQ-025 Bench: rst asserted mid-BUSY -> outputs zero asynchronously; after release, an add request yields 0010 after one cycle.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer_if
// Brief    : Request/result bundle between the control block, the ALU op
//            sequencer and the downstream consumer of alu_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if #(
    parameter int FUNC_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        alu_op;
    logic [FUNC_W-1:0] func;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        alu_ctrl;
    logic              illegal;
    logic              md_start;
    logic              md_busy;

    // Sequencer side: consumes requests, produces results
    modport slave (
        input  in_valid, alu_op, func, out_ready,
        output in_ready, out_valid, alu_ctrl, illegal, md_start, md_busy
    );

    // Requester/consumer side
    modport master (
        output in_valid, alu_op, func, out_ready,
        input  in_ready, out_valid, alu_ctrl, illegal, md_start, md_busy
    );
endinterface : alu_op_sequencer_if
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Decodes alu_op/func into a registered ALU control code and
//            sequences single-cycle versus multi-cycle (mult/div) operations
//            with a valid/ready handshake on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int FUNC_W        = 6,
    parameter int MD_CYCLES     = 32,
    parameter int ENABLE_MULDIV = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    alu_op_sequencer_if.slave  bus
);

    localparam int CNT_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_OUT  = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(MD_CYCLES - 1);

    localparam logic [3:0] c_CTRL_AND  = 4'b0000;
    localparam logic [3:0] c_CTRL_OR   = 4'b0001;
    localparam logic [3:0] c_CTRL_ADD  = 4'b0010;
    localparam logic [3:0] c_CTRL_SUB  = 4'b0110;
    localparam logic [3:0] c_CTRL_SLT  = 4'b0111;
    localparam logic [3:0] c_CTRL_MULT = 4'b1000;
    localparam logic [3:0] c_CTRL_DIV  = 4'b1001;
    localparam logic [3:0] c_CTRL_NOR  = 4'b1100;
    localparam logic [3:0] c_CTRL_ILL  = 4'b1111;

    localparam bit c_MD_EN = (ENABLE_MULDIV != 0);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_alu_ctrl;
    logic             r_illegal;
    logic             r_md_start;

    logic [5:0]       w_f;
    logic [3:0]       w_ctrl;
    logic             w_illegal;
    logic             w_is_md;
    logic             w_in_ready;
    logic             w_xfer;

    // Only the low six bits of func carry the R-type function code
    assign w_f = bus.func[5:0];

    // Opcode decode: anything not explicitly listed falls through as illegal
    always_comb begin
        w_ctrl    = c_CTRL_ILL;
        w_illegal = 1'b1;
        w_is_md   = 1'b0;
        case (bus.alu_op)
            3'b000: begin w_ctrl = c_CTRL_ADD; w_illegal = 1'b0; end
            3'b001: begin w_ctrl = c_CTRL_SUB; w_illegal = 1'b0; end
            3'b011: begin w_ctrl = c_CTRL_AND; w_illegal = 1'b0; end
            3'b100: begin w_ctrl = c_CTRL_OR;  w_illegal = 1'b0; end
            3'b101: begin w_ctrl = c_CTRL_SLT; w_illegal = 1'b0; end
            3'b010: begin
                case (w_f)
                    6'b100000: begin w_ctrl = c_CTRL_ADD; w_illegal = 1'b0; end
                    6'b100010: begin w_ctrl = c_CTRL_SUB; w_illegal = 1'b0; end
                    6'b100100: begin w_ctrl = c_CTRL_AND; w_illegal = 1'b0; end
                    6'b100101: begin w_ctrl = c_CTRL_OR;  w_illegal = 1'b0; end
                    6'b100111: begin w_ctrl = c_CTRL_NOR; w_illegal = 1'b0; end
                    6'b101010: begin w_ctrl = c_CTRL_SLT; w_illegal = 1'b0; end
                    6'b011000: begin
                        if (c_MD_EN) begin
                            w_ctrl    = c_CTRL_MULT;
                            w_illegal = 1'b0;
                            w_is_md   = 1'b1;
                        end
                    end
                    6'b011010: begin
                        if (c_MD_EN) begin
                            w_ctrl    = c_CTRL_DIV;
                            w_illegal = 1'b0;
                            w_is_md   = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Ready depends only on state and downstream ready, never on in_valid
    assign w_in_ready = (r_state == c_IDLE) || ((r_state == c_OUT) && bus.out_ready);
    assign w_xfer     = bus.in_valid && w_in_ready;

    // Next-state selection; an accepted request in OUT chains straight on
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_xfer) w_state_nxt = w_is_md ? c_BUSY : c_OUT;
            end
            c_BUSY: begin
                if (r_cnt == '0) w_state_nxt = c_OUT;
            end
            c_OUT: begin
                if (w_xfer)             w_state_nxt = w_is_md ? c_BUSY : c_OUT;
                else if (bus.out_ready) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // State, result registers, md_start pulse and occupancy counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_alu_ctrl <= 4'b0000;
            r_illegal  <= 1'b0;
            r_md_start <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_md_start <= w_xfer && w_is_md;
            if (w_xfer) begin
                r_alu_ctrl <= w_ctrl;
                r_illegal  <= w_illegal;
            end
            if (w_xfer && w_is_md) begin
                r_cnt <= c_CNT_LOAD;
            end else if ((r_state == c_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == c_OUT);
    assign bus.md_busy   = (r_state == c_BUSY);
    assign bus.md_start  = r_md_start;
    assign bus.alu_ctrl  = r_alu_ctrl;
    assign bus.illegal   = r_illegal;

endmodule : alu_op_sequencer
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Self-checking bench for alu_op_sequencer. A negedge monitor
//            pushes the expected decode of every accepted request into a
//            queue and pops/compares it on every consumed result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [4:0] sb[$];
    logic [4:0] sb_exp;

    alu_op_sequencer_if #(.FUNC_W(6)) bus ();
    alu_op_sequencer_if #(.FUNC_W(6)) bus_nm ();

    alu_op_sequencer #(
        .FUNC_W        (6),
        .MD_CYCLES     (4),
        .ENABLE_MULDIV (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    alu_op_sequencer #(
        .FUNC_W        (6),
        .MD_CYCLES     (4),
        .ENABLE_MULDIV (0)
    ) dut_nm (
        .clk (clk),
        .rst (rst),
        .bus (bus_nm.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode: returns {illegal, alu_ctrl}
    function automatic logic [4:0] exp_of(input logic [2:0] op, input logic [5:0] f,
                                          input bit md_en);
        case (op)
            3'b000: return 5'b0_0010;
            3'b001: return 5'b0_0110;
            3'b011: return 5'b0_0000;
            3'b100: return 5'b0_0001;
            3'b101: return 5'b0_0111;
            3'b010: begin
                if (f == 6'b100000) return 5'b0_0010;
                if (f == 6'b100010) return 5'b0_0110;
                if (f == 6'b100100) return 5'b0_0000;
                if (f == 6'b100101) return 5'b0_0001;
                if (f == 6'b100111) return 5'b0_1100;
                if (f == 6'b101010) return 5'b0_0111;
                if (md_en && f == 6'b011000) return 5'b0_1000;
                if (md_en && f == 6'b011010) return 5'b0_1001;
                return 5'b1_1111;
            end
            default: return 5'b1_1111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [5:0] f);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.func     = f;
    endtask

    // Scoreboard monitor: inputs are stable at negedge, so the handshakes
    // seen here are the ones that complete on the following rising edge
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_result", sb.size(), 1);
                end else begin
                    sb_exp = sb.pop_front();
                    check("sb_result", {bus.illegal, bus.alu_ctrl}, sb_exp);
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(exp_of(bus.alu_op, bus.func, 1'b1));
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.alu_op = 3'b000; bus.func = 6'b0; bus.out_ready = 1'b1;
        bus_nm.in_valid = 1'b0; bus_nm.alu_op = 3'b000; bus_nm.func = 6'b0;
        bus_nm.out_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_alu_ctrl",  bus.alu_ctrl, 4'b0000);
        check("rst_illegal",   bus.illegal, 0);
        check("rst_md_start",  bus.md_start, 0);
        check("rst_md_busy",   bus.md_busy, 0);
        check("rst_in_ready",  bus.in_ready, 1);
        rst = 1'b0;
        tick();

        // R-type sub, one-cycle latency
        drive(3'b010, 6'b100010);
        tick();
        bus.in_valid = 1'b0;
        check("rsub_valid",   bus.out_valid, 1);
        check("rsub_ctrl",    bus.alu_ctrl, 4'b0110);
        check("rsub_illegal", bus.illegal, 0);
        tick();
        check("rsub_idle", bus.out_valid, 0);

        // Back-to-back add / or / slt at full throughput
        drive(3'b000, 6'b0);
        tick();
        check("b2b_add_ctrl", bus.alu_ctrl, 4'b0010);
        check("b2b_add_rdy",  bus.in_ready, 1);
        drive(3'b100, 6'b0);
        tick();
        check("b2b_or_ctrl",  bus.alu_ctrl, 4'b0001);
        check("b2b_or_valid", bus.out_valid, 1);
        check("b2b_or_rdy",   bus.in_ready, 1);
        drive(3'b101, 6'b0);
        tick();
        bus.in_valid = 1'b0;
        check("b2b_slt_ctrl",  bus.alu_ctrl, 4'b0111);
        check("b2b_slt_valid", bus.out_valid, 1);
        tick();

        // Illegal decodes take the single-cycle path
        drive(3'b010, 6'b000001);
        tick();
        check("ill_func_ctrl", bus.alu_ctrl, 4'b1111);
        check("ill_func_flag", bus.illegal, 1);
        check("ill_func_busy", bus.md_busy, 0);
        drive(3'b111, 6'b100000);
        tick();
        check("ill_op7_ctrl", bus.alu_ctrl, 4'b1111);
        check("ill_op7_flag", bus.illegal, 1);
        drive(3'b110, 6'b0);
        tick();
        bus.in_valid = 1'b0;
        check("ill_op6_flag", {bus.illegal, bus.alu_ctrl}, 5'b1_1111);
        tick();

        // Mult decodes as illegal when mult/div is disabled
        bus_nm.in_valid = 1'b1; bus_nm.alu_op = 3'b010; bus_nm.func = 6'b011000;
        tick();
        bus_nm.in_valid = 1'b0;
        check("nomd_valid",   bus_nm.out_valid, 1);
        check("nomd_ctrl",    bus_nm.alu_ctrl, 4'b1111);
        check("nomd_illegal", bus_nm.illegal, 1);
        check("nomd_busy",    bus_nm.md_busy, 0);

        // Result held under backpressure, then exactly one transfer
        bus.out_ready = 1'b0;
        drive(3'b011, 6'b0);
        tick();
        drive(3'b100, 6'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", bus.out_valid, 1);
            check("stall_ctrl",  bus.alu_ctrl, 4'b0000);
            check("stall_rdy",   bus.in_ready, 0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("stall_release_rdy", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        check("stall_next_ctrl", bus.alu_ctrl, 4'b0001);
        tick();
        check("stall_idle", bus.out_valid, 0);

        // Divide: four BUSY cycles, result at cycle five; requests in BUSY ignored
        drive(3'b010, 6'b011010);
        tick();
        drive(3'b000, 6'b0);
        check("div_start_c1", bus.md_start, 1);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) check("div_start_low", bus.md_start, 0);
            check("div_busy",    bus.md_busy, 1);
            check("div_rdy_low", bus.in_ready, 0);
            check("div_no_out",  bus.out_valid, 0);
            if (c == 4) bus.in_valid = 1'b0;
            tick();
        end
        check("div_valid", bus.out_valid, 1);
        check("div_ctrl",  bus.alu_ctrl, 4'b1001);
        check("div_done",  bus.md_busy, 0);
        tick();

        // Reset mid-BUSY aborts the multiply with no result
        drive(3'b010, 6'b011000);
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("abort_busy", bus.md_busy, 1);
        rst = 1'b1;
        #1;
        check("abort_busy_clr", bus.md_busy, 0);
        check("abort_ctrl_clr", bus.alu_ctrl, 4'b0000);
        check("abort_valid",    bus.out_valid, 0);
        check("abort_start",    bus.md_start, 0);
        tick();
        rst = 1'b0;
        tick();
        check("abort_no_result", bus.out_valid, 0);
        drive(3'b000, 6'b0);
        tick();
        bus.in_valid = 1'b0;
        check("post_rst_valid", bus.out_valid, 1);
        check("post_rst_ctrl",  bus.alu_ctrl, 4'b0010);
        tick();
        tick();
        check("sb_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu_op_sequencer
`default_nettype wire
